// File: rtl/program_loader_pkg.sv
// Shared ISA definitions: op selector codes, opcode/funct constants, field positions
// and the loader FSM state type. The CPU decoder imports the same package.
package program_loader_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_ADDU  = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_SLT   = 5'd6,
    OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,
    OP_JR    = 5'd9,
    OP_ADDI  = 5'd10,
    OP_ADDIU = 5'd11,
    OP_ANDI  = 5'd12,
    OP_ORI   = 5'd13,
    OP_SLTI  = 5'd14,
    OP_LW    = 5'd15,
    OP_SW    = 5'd16,
    OP_BEQ   = 5'd17,
    OP_BNE   = 5'd18,
    OP_BGT   = 5'd19,
    OP_BGTE  = 5'd20,
    OP_BLEQ  = 5'd21,
    OP_BLE   = 5'd22,
    OP_J     = 5'd23
  } op_e;

  localparam int unsigned OP_COUNT = 24;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_BNE   = 6'd5;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_ADDIU = 6'd9;
  localparam logic [5:0] OPC_SLTI  = 6'd10;
  localparam logic [5:0] OPC_ANDI  = 6'd12;
  localparam logic [5:0] OPC_ORI   = 6'd13;
  localparam logic [5:0] OPC_BGT   = 6'd23;
  localparam logic [5:0] OPC_BGTE  = 6'd29;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd41;
  localparam logic [5:0] OPC_BLEQ  = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_SLT  = 6'd24;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned FA_LSB  = 21;
  localparam int unsigned FB_LSB  = 16;
  localparam int unsigned FC_LSB  = 11;
  localparam int unsigned SH_LSB  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN
  } state_e;

  function automatic logic [31:0] enc_r(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] sh,
                                        input logic [5:0] funct);
    return {OPC_RTYPE, a, b, c, sh, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] a,
                                        input logic [4:0] b, input logic [15:0] imm);
    return {opc, a, b, imm};
  endfunction

endpackage

// File: rtl/program_loader_instr_encoder.sv
// Combinational encoder: op selector plus operand fields to a 32-bit instruction word.
// Unknown selectors and BLE (whose opcode would alias SW) are flagged illegal.
module instr_encoder
  import program_loader_pkg::*;
(
  input  logic [4:0]  op_sel,
  input  logic [4:0]  f_a,
  input  logic [4:0]  f_b,
  input  logic [4:0]  f_c,
  input  logic [4:0]  f_shamt,
  input  logic [25:0] f_imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [15:0] imm16;
  op_e         op;

  assign imm16 = f_imm[15:0];
  assign op    = op_e'(op_sel);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:   word = enc_r(f_a, f_b, f_c, 5'd0, FN_ADD);
      OP_SUB:   word = enc_r(f_a, f_b, f_c, 5'd0, FN_SUB);
      OP_ADDU:  word = enc_r(f_a, f_b, f_c, 5'd0, FN_ADDU);
      OP_SUBU:  word = enc_r(f_a, f_b, f_c, 5'd0, FN_SUBU);
      OP_AND:   word = enc_r(f_a, f_b, f_c, 5'd0, FN_AND);
      OP_OR:    word = enc_r(f_a, f_b, f_c, 5'd0, FN_OR);
      OP_SLT:   word = enc_r(f_a, f_b, f_c, 5'd0, FN_SLT);
      OP_SLL:   word = enc_r(f_a, f_b, 5'd0, f_shamt, FN_SLL);
      OP_SRL:   word = enc_r(f_a, f_b, 5'd0, f_shamt, FN_SRL);
      OP_JR:    word = {OPC_RTYPE, f_a, 15'd0, FN_JR};
      OP_ADDI:  word = enc_i(OPC_ADDI, f_a, f_b, imm16);
      OP_ADDIU: word = enc_i(OPC_ADDIU, f_a, f_b, imm16);
      OP_ANDI:  word = enc_i(OPC_ANDI, f_a, f_b, imm16);
      OP_ORI:   word = enc_i(OPC_ORI, f_a, f_b, imm16);
      OP_SLTI:  word = enc_i(OPC_SLTI, f_a, f_b, imm16);
      OP_LW:    word = enc_i(OPC_LW, f_a, f_b, imm16);
      OP_SW:    word = enc_i(OPC_SW, f_a, f_b, imm16);
      OP_BEQ:   word = enc_i(OPC_BEQ, f_a, f_b, imm16);
      OP_BNE:   word = enc_i(OPC_BNE, f_a, f_b, imm16);
      OP_BGT:   word = enc_i(OPC_BGT, f_a, f_b, imm16);
      OP_BGTE:  word = enc_i(OPC_BGTE, f_a, f_b, imm16);
      OP_BLEQ:  word = enc_i(OPC_BLEQ, f_a, f_b, imm16);
      OP_J:     word = {OPC_J, f_imm};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Streams symbolic instructions into instruction memory, one write per accepted
// instruction at sequential addresses, and holds the CPU in reset until loading ends.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned BASE_ADDR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_end,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    op_sel,
  input  logic [4:0]    f_a,
  input  logic [4:0]    f_b,
  input  logic [4:0]    f_c,
  input  logic [4:0]    f_shamt,
  input  logic [25:0]   f_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   word_count,
  output logic          full,
  output logic          err_illegal,
  output logic          cpu_hold
);

  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] LAST = '1;

  state_e        state;
  logic [AW-1:0] ptr;
  logic          we_q;
  logic          xfer;
  logic [31:0]   enc_word;
  logic          enc_illegal;

  instr_encoder u_enc (
    .op_sel  (op_sel),
    .f_a     (f_a),
    .f_b     (f_b),
    .f_c     (f_c),
    .f_shamt (f_shamt),
    .f_imm   (f_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // in_ready is only ever high in LOAD, so a transfer implies the LOAD state.
  assign xfer = in_valid & in_ready;

  // The memory commits on the edge closing the mem_we cycle; masking with reset
  // discards a write that is pending when reset arrives.
  assign mem_we = we_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= BASE;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      in_ready    <= 1'b0;
      word_count  <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      cpu_hold    <= 1'b1;
    end else begin
      we_q <= 1'b0;
      // An accepted legal word goes out at the pointer captured now, even if a
      // new load restarts the pointer on this same edge.
      if (xfer && !enc_illegal) begin
        we_q      <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= enc_word;
      end

      if (load_start) begin
        state       <= ST_LOAD;
        ptr         <= BASE;
        word_count  <= '0;
        full        <= 1'b0;
        err_illegal <= 1'b0;
        in_ready    <= 1'b1;
        cpu_hold    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
          end
          ST_LOAD: begin
            cpu_hold <= 1'b1;
            if (xfer) begin
              if (enc_illegal) begin
                err_illegal <= 1'b1;
              end else begin
                word_count <= word_count + 1'b1;
                if (ptr == LAST) begin
                  full     <= 1'b1;
                  in_ready <= 1'b0;
                end else begin
                  ptr <= ptr + 1'b1;
                end
              end
            end
            if (load_end) begin
              state    <= ST_FLUSH;
              in_ready <= 1'b0;
            end
          end
          ST_FLUSH: begin
            // The last accepted word is on the write port during this cycle.
            state    <= ST_RUN;
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
          end
          ST_RUN: begin
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
          end
          default: begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
